pd0_datapath: RTL and testbench

Small PD0 bring-up datapath that bundles three independent functions on one clock and reset.
- A combinational 4-function ALU with zero and negative flags.
- A single registered-data path with synchronous reset.
- A three-stage add-then-subtract pipeline whose result equals op2, two clocks after the operands are presented.

It is a leaf block used to validate the toolflow and package usage before the RISC-V core.

---
 rtl/constants_pkg.sv | 20 ++
 rtl/pd0_datapath_alu.sv | 40 ++++
 rtl/pd0_datapath.sv | 119 +++++++++++
 tb/tb_pd0_datapath.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/constants_pkg.sv
`default_nettype none
// ============================================================================
// Module      : constants_pkg
// Description : Shared constants and types for the PD0 bring-up datapath.
// Revision    : 1.0 - initial release
// ============================================================================
package constants_pkg;

    // ALU operation select encoding
    typedef enum logic [1:0] {
        ADD = 2'd0,
        SUB = 2'd1,
        AND = 2'd2,
        OR  = 2'd3
    } aluSel_e;

    localparam int c_DWIDTH_DEFAULT = 8;

endpackage : constants_pkg
`default_nettype wire

// File: rtl/pd0_datapath_alu.sv
`default_nettype none
// ============================================================================
// Module      : alu
// Description : Combinational 4-function ALU (ADD/SUB/AND/OR) with zero and
//               negative flags derived from the truncated result.
// Revision    : 1.0 - initial release
// ============================================================================
module alu
    import constants_pkg::*;
#(
    parameter int DWIDTH = c_DWIDTH_DEFAULT
) (
    input  aluSel_e           sel_i,
    input  logic [DWIDTH-1:0] op1_i,
    input  logic [DWIDTH-1:0] op2_i,
    output logic [DWIDTH-1:0] res_o,
    output logic              zero_o,
    output logic              neg_o
);

    logic [DWIDTH-1:0] w_res;

    // Select the operation; arithmetic wraps modulo 2^DWIDTH
    always_comb begin
        w_res = '0;
        case (sel_i)
            ADD:     w_res = op1_i + op2_i;
            SUB:     w_res = op1_i - op2_i;
            AND:     w_res = op1_i & op2_i;
            OR:      w_res = op1_i | op2_i;
            default: w_res = '0;
        endcase
    end

    assign res_o  = w_res;
    assign zero_o = (w_res == '0);
    assign neg_o  = w_res[DWIDTH-1];

endmodule : alu
`default_nettype wire

// File: rtl/pd0_datapath.sv
`default_nettype none
// ============================================================================
// Module      : pd0_datapath
// Description : PD0 bring-up datapath: exposed combinational ALU, a single
//               registered-data path, and a three-stage add-then-subtract
//               pipeline whose result reproduces op2 two clocks later.
// Revision    : 1.0 - initial release
// ============================================================================
module pd0_datapath
    import constants_pkg::*;
#(
    parameter int DWIDTH = c_DWIDTH_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    // Exposed ALU
    input  logic [1:0]        alu_sel_i,
    input  logic [DWIDTH-1:0] alu_op1_i,
    input  logic [DWIDTH-1:0] alu_op2_i,
    output logic [DWIDTH-1:0] alu_res_o,
    output logic              alu_zero_o,
    output logic              alu_neg_o,
    // Register path
    input  logic [DWIDTH-1:0] reg_in_i,
    output logic [DWIDTH-1:0] reg_out_o,
    // Add-then-subtract pipeline
    input  logic [DWIDTH-1:0] tsp_op1_i,
    input  logic [DWIDTH-1:0] tsp_op2_i,
    output logic [DWIDTH-1:0] tsp_res_o
);

    logic [DWIDTH-1:0] r_reg;
    logic [DWIDTH-1:0] r_s1_sum;
    logic [DWIDTH-1:0] r_s1_op1;
    logic [DWIDTH-1:0] r_tsp_res;

    logic [DWIDTH-1:0] w_sum;
    logic [DWIDTH-1:0] w_diff;

    // Pipeline ALU flags are not needed; names keep them visibly unused
    logic              w_unused_s1_zero;
    logic              w_unused_s1_neg;
    logic              w_unused_s2_zero;
    logic              w_unused_s2_neg;

    // ------------------------------------------------------------------
    // Exposed ALU: purely combinational, independent of clk/rst
    // ------------------------------------------------------------------
    alu #(.DWIDTH(DWIDTH)) u_alu_main (
        .sel_i  (aluSel_e'(alu_sel_i)),
        .op1_i  (alu_op1_i),
        .op2_i  (alu_op2_i),
        .res_o  (alu_res_o),
        .zero_o (alu_zero_o),
        .neg_o  (alu_neg_o)
    );

    // ------------------------------------------------------------------
    // Register path
    // ------------------------------------------------------------------
    // One-cycle data register; reset takes priority over new data
    always_ff @(posedge clk) begin
        if (rst) begin
            r_reg <= '0;
        end else begin
            r_reg <= reg_in_i;
        end
    end

    assign reg_out_o = r_reg;

    // ------------------------------------------------------------------
    // Pipeline stage 1: sum = op1 + op2
    // ------------------------------------------------------------------
    alu #(.DWIDTH(DWIDTH)) u_alu_s1 (
        .sel_i  (ADD),
        .op1_i  (tsp_op1_i),
        .op2_i  (tsp_op2_i),
        .res_o  (w_sum),
        .zero_o (w_unused_s1_zero),
        .neg_o  (w_unused_s1_neg)
    );

    // Capture the wrapped sum alongside op1 so stage 2 can undo the add
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_sum <= '0;
            r_s1_op1 <= '0;
        end else begin
            r_s1_sum <= w_sum;
            r_s1_op1 <= tsp_op1_i;
        end
    end

    // ------------------------------------------------------------------
    // Pipeline stage 2: diff = sum - op1, which recovers op2 mod 2^DWIDTH
    // ------------------------------------------------------------------
    alu #(.DWIDTH(DWIDTH)) u_alu_s2 (
        .sel_i  (SUB),
        .op1_i  (r_s1_sum),
        .op2_i  (r_s1_op1),
        .res_o  (w_diff),
        .zero_o (w_unused_s2_zero),
        .neg_o  (w_unused_s2_neg)
    );

    // Stage 3 output register driving the pipeline result
    always_ff @(posedge clk) begin
        if (rst) begin
            r_tsp_res <= '0;
        end else begin
            r_tsp_res <= w_diff;
        end
    end

    assign tsp_res_o = r_tsp_res;

endmodule : pd0_datapath
`default_nettype wire

// File: tb/tb_pd0_datapath.sv
`default_nettype none
// ============================================================================
// Module      : tb_pd0_datapath
// Description : Directed self-checking bench for pd0_datapath.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pd0_datapath;

    localparam int DWIDTH = 8;

    logic              clk;
    logic              rst;
    logic [1:0]        alu_sel_i;
    logic [DWIDTH-1:0] alu_op1_i;
    logic [DWIDTH-1:0] alu_op2_i;
    logic [DWIDTH-1:0] alu_res_o;
    logic              alu_zero_o;
    logic              alu_neg_o;
    logic [DWIDTH-1:0] reg_in_i;
    logic [DWIDTH-1:0] reg_out_o;
    logic [DWIDTH-1:0] tsp_op1_i;
    logic [DWIDTH-1:0] tsp_op2_i;
    logic [DWIDTH-1:0] tsp_res_o;

    int checks   = 0;
    int failures = 0;

    pd0_datapath #(.DWIDTH(DWIDTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .alu_sel_i  (alu_sel_i),
        .alu_op1_i  (alu_op1_i),
        .alu_op2_i  (alu_op2_i),
        .alu_res_o  (alu_res_o),
        .alu_zero_o (alu_zero_o),
        .alu_neg_o  (alu_neg_o),
        .reg_in_i   (reg_in_i),
        .reg_out_o  (reg_out_o),
        .tsp_op1_i  (tsp_op1_i),
        .tsp_op2_i  (tsp_op2_i),
        .tsp_res_o  (tsp_res_o)
    );

    // 10 ns clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compare one observed value against its expected value
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle just after it
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Apply ALU operands and let the combinational result settle
    task automatic alu_apply(input logic [1:0] sel, input logic [7:0] a, input logic [7:0] b);
        alu_sel_i = sel;
        alu_op1_i = a;
        alu_op2_i = b;
        #1;
    endtask

    initial begin
        rst       = 1'b1;
        alu_sel_i = 2'd0;
        alu_op1_i = '0;
        alu_op2_i = '0;
        reg_in_i  = '0;
        tsp_op1_i = '0;
        tsp_op2_i = '0;

        tick();
        tick();
        check("reset_reg_out", 32'(reg_out_o), 32'd0);
        check("reset_tsp_res", 32'(tsp_res_o), 32'd0);

        // ALU while rst is held high
        alu_apply(2'd0, 8'd10, 8'd3);
        check("alu_add_res",  32'(alu_res_o),  32'd13);
        check("alu_add_zero", 32'(alu_zero_o), 32'd0);
        check("alu_add_neg",  32'(alu_neg_o),  32'd0);
        alu_apply(2'd1, 8'd10, 8'd3);
        check("alu_sub_res", 32'(alu_res_o), 32'd7);

        // ALU with rst low
        rst = 1'b0;
        alu_apply(2'd1, 8'd3, 8'd10);
        check("alu_subneg_res", 32'(alu_res_o), 32'hF9);
        check("alu_subneg_neg", 32'(alu_neg_o), 32'd1);
        alu_apply(2'd2, 8'hF0, 8'h0F);
        check("alu_and_res",  32'(alu_res_o),  32'd0);
        check("alu_and_zero", 32'(alu_zero_o), 32'd1);
        check("alu_and_neg",  32'(alu_neg_o),  32'd0);
        alu_apply(2'd3, 8'hA5, 8'h5A);
        check("alu_or_res",  32'(alu_res_o),  32'hFF);
        check("alu_or_zero", 32'(alu_zero_o), 32'd0);
        check("alu_or_neg",  32'(alu_neg_o),  32'd1);

        // Register path
        reg_in_i = 8'd9;
        tick();
        check("reg_9", 32'(reg_out_o), 32'd9);
        reg_in_i = 8'd8;
        tick();
        check("reg_8", 32'(reg_out_o), 32'd8);
        rst = 1'b1;
        tick();
        check("reg_rst", 32'(reg_out_o), 32'd0);
        rst = 1'b0;

        // Pipeline back-to-back
        tsp_op1_i = 8'd5;  tsp_op2_i = 8'd21;
        tick();
        check("tsp_fill", 32'(tsp_res_o), 32'd0);
        tsp_op1_i = 8'd12; tsp_op2_i = 8'd7;
        tick();
        check("tsp_b2b_21", 32'(tsp_res_o), 32'd21);
        tsp_op1_i = 8'd0;  tsp_op2_i = 8'd0;
        tick();
        check("tsp_b2b_7", 32'(tsp_res_o), 32'd7);
        tick();
        check("tsp_b2b_0", 32'(tsp_res_o), 32'd0);

        // Pipeline overflow: 200+100 wraps to 44, 44-200 wraps back to 100
        tsp_op1_i = 8'd200; tsp_op2_i = 8'd100;
        tick();
        tsp_op1_i = 8'd0;   tsp_op2_i = 8'd0;
        tick();
        check("tsp_overflow", 32'(tsp_res_o), 32'd100);

        // Pipeline reset mid-stream: 21 must never surface
        tsp_op1_i = 8'd5; tsp_op2_i = 8'd21;
        tick();
        rst = 1'b1;
        tsp_op1_i = 8'd0; tsp_op2_i = 8'd0;
        tick();
        check("tsp_midrst_0", 32'(tsp_res_o), 32'd0);
        rst = 1'b0;
        tick();
        check("tsp_midrst_1", 32'(tsp_res_o), 32'd0);
        tick();
        check("tsp_midrst_2", 32'(tsp_res_o), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_pd0_datapath
`default_nettype wire
